// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin arbiter in front of a single-port RAM,
// with an optional zero-fill sweep after reset.
module ram_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic          ram_ena,
  output logic          ram_wena,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);
  typedef enum logic [1:0] {CLEAR, IDLE, ISSUE, RDWAIT} state_t;
  state_t        state;
  logic [AW-1:0] cnt, cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          cmd_we, owner, last, idle;
  // outputs decode registered state only; rst_n gating keeps them at 0 during reset
  assign idle      = rst_n && state == IDLE;
  assign m0_gnt    = idle && m0_req && (!m1_req || last);
  assign m1_gnt    = idle && m1_req && (!m0_req || !last);
  assign busy      = rst_n && state == CLEAR;
  assign ram_ena   = rst_n && (state == CLEAR || state == ISSUE);
  assign ram_wena  = rst_n && (state == CLEAR || (state == ISSUE && cmd_we));
  assign ram_addr  = !rst_n ? '0 : state == CLEAR ? cnt : state == ISSUE ? cmd_addr : '0;
  assign ram_wdata = (rst_n && state == ISSUE) ? cmd_wdata : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= CLEAR_ON_RESET ? CLEAR : IDLE;
      cnt       <= '0;
      last      <= 1'b1;
      owner     <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      case (state)
        CLEAR: if (cnt == '1) state <= IDLE; else cnt <= cnt + 1'b1;
        IDLE: if (m0_gnt || m1_gnt) begin
          owner     <= m1_gnt;
          last      <= m1_gnt;
          cmd_we    <= m1_gnt ? m1_we : m0_we;
          cmd_addr  <= m1_gnt ? m1_addr : m0_addr;
          cmd_wdata <= m1_gnt ? m1_wdata : m0_wdata;
          state     <= ISSUE;
        end
        ISSUE: state <= cmd_we ? IDLE : RDWAIT;
        RDWAIT: begin
          if (owner) begin
            m1_rdata  <= ram_rdata;
            m1_rvalid <= 1'b1;
          end else begin
            m0_rdata  <= ram_rdata;
            m0_rvalid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and randomized checks of ram_arbiter against a
// transaction-level memory and round-robin model.
module tb_ram_arbiter;
  localparam int DW = 32, AW = 5, DEPTH = 32;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic m0_req, m1_req, m0_we, m1_we, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic ram_ena, ram_wena, busy;
  logic [AW-1:0] m0_addr, m1_addr, ram_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, ram_wdata, ram_rdata;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic b_m1_req, b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_ram_ena, b_ram_wena, b_busy;
  logic [AW-1:0] b_ram_addr;
  logic [DW-1:0] b_m0_rdata, b_m1_rdata, b_ram_wdata;
  logic [DW-1:0] b_ram_rdata = '0;
  int checks = 0, errors = 0, last_win = 1;

  ram_arbiter #(.DW(DW), .AW(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy));

  ram_arbiter #(.DW(DW), .AW(AW), .CLEAR_ON_RESET(1'b0)) dut_nc (
    .clk(clk), .rst_n(rst_n),
    .m0_req(1'b0), .m0_we(1'b0), .m0_addr('0), .m0_wdata('0),
    .m1_req(b_m1_req), .m1_we(1'b1), .m1_addr(5'd3), .m1_wdata(32'h1234),
    .m0_gnt(b_m0_gnt), .m1_gnt(b_m1_gnt), .m0_rdata(b_m0_rdata), .m1_rdata(b_m1_rdata),
    .m0_rvalid(b_m0_rvalid), .m1_rvalid(b_m1_rvalid),
    .ram_ena(b_ram_ena), .ram_wena(b_ram_wena), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
    .ram_rdata(b_ram_rdata), .busy(b_busy));

  // single-port RAM with one cycle read latency
  always @(posedge clk)
    if (ram_ena) begin
      if (ram_wena) mem[ram_addr] = ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // entered at the grant negedge; returns just after a rising edge with the DUT idle
  task automatic finish_txn(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    @(negedge clk);
    chk("cmd_ena", ram_ena, 1);
    chk("cmd_wena", ram_wena, we);
    chk("cmd_addr", ram_addr, a);
    if (we) chk("cmd_wdata", ram_wdata, d);
    chk("issue_gnt", {m0_gnt, m1_gnt}, 0);
    if (we) begin
      ref_mem[a] = d;
      @(posedge clk); #1;
    end else begin
      @(negedge clk);
      chk("rdwait_outs", {ram_ena, ram_wena, m0_rvalid, m1_rvalid, m0_gnt, m1_gnt}, 0);
      @(negedge clk);
      chk("rvalid", {m0_rvalid, m1_rvalid}, p == 1 ? 2'b01 : 2'b10);
      chk("rdata", p == 1 ? m1_rdata : m0_rdata, ref_mem[a]);
      @(posedge clk); #1;
    end
  endtask

  task automatic step(input int mask, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    int waits = 0, w;
    logic found = 1'b0;
    m0_req = mask[0]; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = mask[1]; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    while (!found && waits < 20) begin
      @(negedge clk);
      waits++;
      found = m0_gnt | m1_gnt;
    end
    chk("gnt_latency", waits, 1);
    if (!found) begin
      m0_req = 1'b0;
      m1_req = 1'b0;
      return;
    end
    w = mask == 1 ? 0 : mask == 2 ? 1 : (last_win == 1 ? 0 : 1);
    chk("winner", {m0_gnt, m1_gnt}, w == 1 ? 2'b01 : 2'b10);
    last_win = w;
    if (w == 1) finish_txn(1, w1, a1, d1);
    else finish_txn(0, w0, a0, d0);
  endtask

  initial begin
    int mask, n, gap, exp_w;
    logic w0, w1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = '0;
    end
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    b_m1_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_ena, ram_wena, busy, ram_addr}, 0);
    chk("rst_data", {ram_wdata, m0_rdata | m1_rdata}, 0);
    chk("rst_nc_outs", {b_m1_gnt, b_busy, b_ram_ena}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk("fill_ctl", {ram_ena, ram_wena, busy, m0_gnt, m1_gnt}, 5'b11100);
      chk("fill_addr", ram_addr, i);
      chk("fill_wdata", ram_wdata, 0);
      if (i == 0) chk("nc_first", {b_m1_gnt, b_busy, b_ram_ena}, 3'b100);
      if (i == 1) b_m1_req = 1'b0;
    end
    @(negedge clk);
    chk("post_fill", {busy, m0_gnt, m1_gnt}, 3'b010);
    last_win = 0;
    finish_txn(0, 1'b0, 5'd0, '0);
    step(1, 1'b1, 5'd5, 32'hFFFF_FFFF, 1'b0, '0, '0);
    step(1, 1'b0, 5'd5, '0, 1'b0, '0, '0);
    // m1 alone: back-to-back writes to the two address extremes
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 5'd31; m1_wdata = 32'hFFFF_FFFE;
    @(negedge clk);
    chk("m1_gnt_a", {m0_gnt, m1_gnt}, 2'b01);
    @(posedge clk); #1;
    m1_addr = 5'd0; m1_wdata = 32'hFFFF_FFFD;
    @(negedge clk);
    chk("m1_cmd_a", {ram_ena, ram_wena, ram_addr, ram_wdata}, {2'b11, 5'd31, 32'hFFFF_FFFE});
    chk("m1_issue_gnt", {m0_gnt, m1_gnt}, 0);
    ref_mem[31] = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    @(negedge clk);
    chk("m1_gnt_b", {m0_gnt, m1_gnt}, 2'b01);
    last_win = 1;
    finish_txn(1, 1'b1, 5'd0, 32'hFFFF_FFFD);
    step(2, 1'b0, '0, '0, 1'b0, 5'd31, '0);
    step(2, 1'b0, '0, '0, 1'b0, 5'd0, '0);
    // both ports hold reads: grants must alternate every third cycle
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 5'd5;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 5'd31;
    exp_w = last_win == 1 ? 0 : 1;
    n = 0;
    gap = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(negedge clk);
      gap++;
      if (m0_rvalid) chk("rr_rdata0", m0_rdata, ref_mem[5]);
      if (m1_rvalid) chk("rr_rdata1", m1_rdata, ref_mem[31]);
      if (m0_gnt || m1_gnt) begin
        chk("rr_winner", {m0_gnt, m1_gnt}, exp_w == 1 ? 2'b01 : 2'b10);
        if (n > 0) chk("rr_gap", gap, 3);
        last_win = exp_w;
        exp_w = 1 - exp_w;
        gap = 0;
        n++;
      end
    end
    chk("rr_count", n, 4);
    @(posedge clk); #1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    repeat (40) begin
      mask = $urandom_range(1, 3);
      w0 = 1'($urandom_range(0, 1)); a0 = 5'($urandom); d0 = $urandom;
      w1 = 1'($urandom_range(0, 1)); a1 = 5'($urandom); d1 = $urandom;
      step(mask, w0, a0, d0, w1, a1, d1);
    end
    // reset in the middle of a read
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 5'd5;
    @(negedge clk);
    chk("abort_gnt", {m0_gnt, m1_gnt}, 2'b10);
    @(posedge clk); #1;
    m0_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_ena, ram_wena, busy, ram_addr}, 0);
    chk("abort_data", {ram_wdata, m0_rdata | m1_rdata}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    last_win = 1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk("refill_ctl", {ram_ena, ram_wena, busy, m0_rvalid, m1_rvalid}, 5'b11100);
      chk("refill_addr", ram_addr, i);
    end
    @(negedge clk);
    chk("refill_done", {busy, m0_rvalid, m1_rvalid}, 0);
    @(posedge clk); #1;
    step(3, 1'b0, 5'd5, '0, 1'b0, 5'd31, '0);
    step(2, 1'b0, '0, '0, 1'b0, 5'd0, '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DW, 32, data width of the shared RAM word.
REQ-002 Parameter AW, 5, RAM address width; depth is 2**AW words.
REQ-003 Parameter CLEAR_ON_RESET, 1, when 1 the block zero-fills the RAM after reset; when 0 it skips the fill.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low, with ports named as follows.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 m0_req, m1_req  in  1  requester has a pending access; held until granted.
REQ-008 m0_we, m1_we  in  1  1 = write, 0 = read; held with req.
REQ-009 m0_addr, m1_addr  in  AW  access address; held with req.
REQ-010 m0_wdata, m1_wdata  in  DW  write data; held with req.
REQ-011 m0_gnt, m1_gnt  out  1  one-cycle acceptance of the pending request.
REQ-012 m0_rdata, m1_rdata  out  DW  read result, valid while the matching rvalid is high; holds its value otherwise.
REQ-013 m0_rvalid, m1_rvalid  out  1  one-cycle read-data-valid pulse.
REQ-014 ram_ena, ram_wena, ram_addr (AW), ram_wdata (DW)  out  registered command to the RAM.
REQ-015 ram_rdata  in  DW  RAM read data, valid the cycle after a read command.
REQ-016 busy  out  1  high while the zero-fill runs.

Function
REQ-017 FSM states SHALL be CLEAR, IDLE, ISSUE, RDWAIT.
REQ-018 CLEAR: each cycle drive ram_ena=1, ram_wena=1, ram_addr=fill counter, ram_wdata=0; counter +1; after address 2**AW-1 go to IDLE; busy=1; no grants; fill lasts exactly 2**AW cycles.
REQ-019 IDLE: gnt SHALL be combinational, to at most one requester; a lone requester wins; on a tie, the requester that did not win last SHALL win (round-robin).
REQ-020 On the edge ending a grant cycle: latch the winner's we/addr/wdata into ram_*, record the winner, update the last-winner pointer, go to ISSUE.
REQ-021 ISSUE: ram_ena=1 for exactly one cycle; a write goes to IDLE; a read goes to RDWAIT.
REQ-022 RDWAIT: capture ram_rdata into the winner's rdata register; that rvalid SHALL be high the next cycle, and state returns to IDLE in that same cycle.
REQ-023 Latency: write = gnt at N, RAM write command at N+1, next grant possible at N+2; read = gnt at N, command at N+1, rvalid/rdata at N+3, next grant possible at N+3.
REQ-024 In IDLE and RDWAIT, ram_ena and ram_wena SHALL be 0, and ram_addr/ram_wdata SHALL be 0.
REQ-025 A req dropped before gnt SHALL be ignored.
REQ-026 gnt SHALL never be asserted outside IDLE.
REQ-027 rvalid SHALL never be asserted for a write, or on the non-owning port.
REQ-028 The fill counter SHALL be AW bits and stop at terminal count; it SHALL NOT wrap into a second sweep.

Reset
REQ-029 While rst_n=0, all outputs SHALL be 0 immediately (asynchronous), including rdata registers and busy.
REQ-030 Reset SHALL load: state = CLEAR (CLEAR_ON_RESET=1) or IDLE (0); fill counter = 0; last-winner = m1, so m0 wins the first tie.
REQ-031 Reset asserted mid-operation SHALL abort the access: no pending gnt or rvalid is produced afterward, and the fill restarts at address 0.

Verification
REQ-032 Release reset, CLEAR_ON_RESET=1, m0_req=1 -> 32 cycles of ram_ena=ram_wena=1, addr 0..31, wdata 0, busy=1, no gnt; then busy=0 and m0_gnt=1 in the first IDLE cycle.
REQ-033 m0 writes 0xFFFFFFFF to addr 5, then reads addr 5 -> write command appears the cycle after gnt; m0_rvalid=1 with m0_rdata=0xFFFFFFFF three cycles after the read gnt; m1_rvalid stays 0.
REQ-034 m0 and m1 both hold read requests continuously -> grants alternate m0, m1, m0, m1, with 3 cycles between grants.
REQ-035 Only m1 requests, writing addr 31 with 0xFFFFFFFE and then addr 0 with 0xFFFFFFFD -> both accepted, 2 cycles apart; readback returns the matching values, and addr 31 does not alias addr 0.
REQ-036 Assert rst_n=0 during RDWAIT -> all outputs 0 at once, no rvalid after release, fill restarts at addr 0.
REQ-037 CLEAR_ON_RESET=0, release reset with m1_req=1 -> no fill, busy stays 0, m1_gnt=1 in the first cycle after release.
